syncbank: RTL and testbench



---
 rtl/syncbank_pkg.sv | 27 ++
 rtl/syncbank_channel.sv | 106 ++++++++++
 rtl/syncbank.sv | 47 ++++
 tb/tb_syncbank.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/syncbank_pkg.sv
// syncbank_pkg: shared defaults and width helpers for the syncbank input
// synchroniser.
//   STAGES_DEF - default synchroniser chain depth
//   FILTER_DEF - default glitch-filter length (0 = filter bypassed)
//   clog2      - constant ceiling-log2
//   cnt_width  - filter counter width, never narrower than one bit
package syncbank_pkg;

  localparam int STAGES_DEF = 2;
  localparam int FILTER_DEF = 0;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) begin
      result = result + 1;
    end
    return result;
  endfunction

  // Filter counts 0..FILTER-1, so clog2(FILTER) bits suffice; FILTER=1 still
  // needs a one-bit counter to keep the vector legal.
  function automatic int cnt_width(input int filter);
    return (clog2(filter) < 1) ? 1 : clog2(filter);
  endfunction

endpackage

// File: rtl/syncbank_channel.sv
// syncbank_channel: one channel of the input synchroniser bank.
//   clock  - system clock, all flops on posedge
//   reset  - asynchronous, active-high; forces every flop to INIT_BIT / 0
//   async  - unsynchronised input
//   sync   - synchronised (and optionally filtered) level, registered
//   rise   - one-clock pulse on a 0->1 change of sync
//   fall   - one-clock pulse on a 1->0 change of sync
// Build option: define SYNCBANK_EDGES_EN to build the edge detector; without
// it rise/fall are tied low and no history flop exists.
module syncbank_channel
  import syncbank_pkg::*;
#(
  parameter int   STAGES   = STAGES_DEF,
  parameter int   FILTER   = FILTER_DEF,
  parameter logic INIT_BIT = 1'b0
) (
  input  logic clock,
  input  logic reset,
  input  logic async,
  output logic sync,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] chain_q;
  logic [STAGES-1:0] chain_d;
  logic              raw;

  always_comb begin
    chain_d = {chain_q[STAGES-2:0], async};
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      chain_q <= {STAGES{INIT_BIT}};
    end else begin
      chain_q <= chain_d;
    end
  end

  assign raw = chain_q[STAGES-1];

  generate
    if (FILTER == 0) begin : g_bypass
      assign sync = raw;
    end else begin : g_filter
      localparam int CNT_W = cnt_width(FILTER);

      logic [CNT_W-1:0] cnt_q;
      logic [CNT_W-1:0] cnt_d;
      logic             level_q;
      logic             level_d;

      // Any sample matching the current level clears the count, so a new
      // level has to persist FILTER consecutive clocks; the count is
      // consumed on the accepting clock and therefore never wraps.
      always_comb begin
        cnt_d   = '0;
        level_d = level_q;
        if (raw != level_q) begin
          if (cnt_q == CNT_W'(FILTER - 1)) begin
            level_d = raw;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end

      always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
          cnt_q   <= '0;
          level_q <= INIT_BIT;
        end else begin
          cnt_q   <= cnt_d;
          level_q <= level_d;
        end
      end

      assign sync = level_q;
    end
  endgenerate

`ifdef SYNCBANK_EDGES_EN
  logic sync_q;
  logic sync_d;

  assign sync_d = sync;

  // History resets to the same level as sync, so reset and its release
  // never produce a pulse.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync_q <= INIT_BIT;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign rise = sync & ~sync_q;
  assign fall = ~sync & sync_q;
`else
  assign rise = 1'b0;
  assign fall = 1'b0;
`endif

endmodule

// File: rtl/syncbank.sv
// syncbank: bank of CHANNELS independent input synchronisers with optional
// glitch filter, placed directly behind the input pads.
//   clock  - system clock, all flops on posedge
//   reset  - asynchronous, active-high
//   async  - [CHANNELS] unsynchronised inputs
//   sync   - [CHANNELS] synchronised / filtered levels
//   rise   - [CHANNELS] one-clock pulse per 0->1 change of sync
//   fall   - [CHANNELS] one-clock pulse per 1->0 change of sync
// Build option: SYNCBANK_EDGES_EN enables rise/fall; otherwise they read 0.
module syncbank
  import syncbank_pkg::*;
#(
  parameter int                  CHANNELS = 1,
  parameter int                  STAGES   = STAGES_DEF,
  parameter int                  FILTER   = FILTER_DEF,
  parameter logic [CHANNELS-1:0] INIT     = {CHANNELS{1'b0}}
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [CHANNELS-1:0] async,
  output logic [CHANNELS-1:0] sync,
  output logic [CHANNELS-1:0] rise,
  output logic [CHANNELS-1:0] fall
);

  generate
    if (STAGES < 2) begin : g_bad_stages
      $error("syncbank: STAGES must be at least 2");
    end

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
      syncbank_channel #(
        .STAGES   (STAGES),
        .FILTER   (FILTER),
        .INIT_BIT (INIT[i])
      ) u_channel (
        .clock (clock),
        .reset (reset),
        .async (async[i]),
        .sync  (sync[i]),
        .rise  (rise[i]),
        .fall  (fall[i])
      );
    end
  endgenerate

endmodule

// File: tb/tb_syncbank.sv
// tb_syncbank: directed bench for syncbank.
//   dut_a: CHANNELS=4, STAGES=3, FILTER=0, INIT=4'b1010
//   dut_b: CHANNELS=8, STAGES=2, FILTER=4, INIT=0
// Edge expectations follow SYNCBANK_EDGES_EN; without it rise/fall must be 0.
module tb_syncbank;

`ifdef SYNCBANK_EDGES_EN
  localparam bit EDGES = 1'b1;
`else
  localparam bit EDGES = 1'b0;
`endif

  logic       clock;
  logic       reset;
  logic [3:0] a_async, a_sync, a_rise, a_fall;
  logic [7:0] b_async, b_sync, b_rise, b_fall;
  int         checks;
  int         errors;

  syncbank #(
    .CHANNELS (4),
    .STAGES   (3),
    .FILTER   (0),
    .INIT     (4'b1010)
  ) dut_a (
    .clock (clock),
    .reset (reset),
    .async (a_async),
    .sync  (a_sync),
    .rise  (a_rise),
    .fall  (a_fall)
  );

  syncbank #(
    .CHANNELS (8),
    .STAGES   (2),
    .FILTER   (4),
    .INIT     (8'h00)
  ) dut_b (
    .clock (clock),
    .reset (reset),
    .async (b_async),
    .sync  (b_sync),
    .rise  (b_rise),
    .fall  (b_fall)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks = checks + 1;
    assert (obs === exp)
    else begin
      errors = errors + 1;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] edge_exp(input logic [7:0] v);
    return EDGES ? v : 8'h00;
  endfunction

  logic [7:0] pat;

  initial begin
    checks  = 0;
    errors  = 0;
    reset   = 1'b0;
    a_async = 4'b0101;
    b_async = 8'h00;
    pat     = 8'b1111_0111;

    // asynchronous reset before any clock edge
    #2 reset = 1'b1;
    #1;
    chk("rst_a_sync_async", {4'h0, a_sync}, 8'h0A);
    chk("rst_b_sync_async", b_sync, 8'h00);
    chk("rst_a_rise", {4'h0, a_rise}, 8'h00);
    chk("rst_a_fall", {4'h0, a_fall}, 8'h00);

    // reset dominates clock edges even with opposite inputs
    tick();
    tick();
    chk("rst_held_a_sync", {4'h0, a_sync}, 8'h0A);
    a_async = 4'b1010;
    #2 reset = 1'b0;
    tick();
    chk("release_a_sync", {4'h0, a_sync}, 8'h0A);
    chk("release_a_rise", {4'h0, a_rise}, 8'h00);
    chk("release_a_fall", {4'h0, a_fall}, 8'h00);
    chk("release_b_sync", b_sync, 8'h00);
    tick();
    tick();

    // dut_a latency: STAGES=3, no filter
    a_async[0] = 1'b1;
    tick();
    tick();
    chk("lat_k2_a_sync", {4'h0, a_sync}, 8'h0A);
    tick();
    chk("lat_k3_a_sync", {4'h0, a_sync}, 8'h0B);
    chk("lat_k3_a_rise", {4'h0, a_rise}, edge_exp(8'h01));
    tick();
    chk("lat_k4_a_rise", {4'h0, a_rise}, 8'h00);
    chk("lat_k4_a_sync", {4'h0, a_sync}, 8'h0B);

    // dut_a fall on channel 3 (INIT high)
    a_async[3] = 1'b0;
    tick();
    tick();
    chk("fall_k2_a_sync", {4'h0, a_sync}, 8'h0B);
    tick();
    chk("fall_k3_a_sync", {4'h0, a_sync}, 8'h03);
    chk("fall_k3_a_fall", {4'h0, a_fall}, edge_exp(8'h08));
    tick();
    chk("fall_k4_a_fall", {4'h0, a_fall}, 8'h00);

    // dut_b glitch: three clocks high never reaches sync
    b_async[2] = 1'b1;
    for (int i = 1; i <= 7; i++) begin
      tick();
      chk("glitch3_b_sync", b_sync, 8'h00);
      if (i == 3) b_async[2] = 1'b0;
    end
    tick();

    // dut_b: four clocks high passes, sync rises at 2+4 clocks
    b_async[2] = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      tick();
      chk("pass4_pre_b_sync", b_sync, 8'h00);
      if (i == 4) b_async[2] = 1'b0;
    end
    tick();
    chk("pass4_k6_b_sync", b_sync, 8'h04);
    chk("pass4_k6_b_rise", b_rise, edge_exp(8'h04));
    tick();
    chk("pass4_k7_b_sync", b_sync, 8'h04);
    chk("pass4_k7_b_rise", b_rise, 8'h00);
    tick();
    tick();
    chk("pass4_k9_b_sync", b_sync, 8'h04);
    tick();
    chk("pass4_k10_b_sync", b_sync, 8'h00);
    chk("pass4_k10_b_fall", b_fall, edge_exp(8'h04));
    tick();
    chk("pass4_k11_b_fall", b_fall, 8'h00);

    // dut_b count restart: raw 1,1,1,0,1,1,1,1
    for (int j = 0; j < 8; j++) begin
      b_async[2] = pat[j];
      tick();
      chk("restart_pre_b_sync", b_sync, 8'h00);
    end
    tick();
    chk("restart_k9_b_sync", b_sync, 8'h00);
    tick();
    chk("restart_k10_b_sync", b_sync, 8'h04);
    b_async[2] = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    chk("restart_fall_pre_b_sync", b_sync, 8'h04);
    tick();
    chk("restart_fall_b_sync", b_sync, 8'h00);

    // dut_b channel independence: ch0 first, ch3 and ch7 one clock later
    b_async[0] = 1'b1;
    tick();
    b_async[3] = 1'b1;
    b_async[7] = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    chk("indep_k5_b_sync", b_sync, 8'h00);
    tick();
    chk("indep_k6_b_sync", b_sync, 8'h01);
    chk("indep_k6_b_rise", b_rise, edge_exp(8'h01));
    tick();
    chk("indep_k7_b_sync", b_sync, 8'h89);
    chk("indep_k7_b_rise", b_rise, edge_exp(8'h88));

    // reset mid-count: ch4 counting up, ch0/3/7 counting down
    b_async = 8'h10;
    for (int i = 0; i < 4; i++) tick();
    chk("abort_pre_b_sync", b_sync, 8'h89);
    #2 reset = 1'b1;
    #1;
    chk("abort_b_sync", b_sync, 8'h00);
    chk("abort_a_sync", {4'h0, a_sync}, 8'h0A);
    chk("abort_b_fall", b_fall, 8'h00);
    chk("abort_a_rise", {4'h0, a_rise}, 8'h00);
    tick();
    chk("abort_held_b_sync", b_sync, 8'h00);
    a_async = 4'b1010;
    reset = 1'b0;
    tick();
    chk("abort_rel_a_sync", {4'h0, a_sync}, 8'h0A);
    chk("abort_rel_a_rise", {4'h0, a_rise}, 8'h00);
    for (int i = 0; i < 4; i++) tick();
    chk("abort_r5_b_sync", b_sync, 8'h00);
    tick();
    chk("abort_r6_b_sync", b_sync, 8'h10);
    chk("abort_r6_b_rise", b_rise, edge_exp(8'h10));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
